// File: rtl/beep_pkg.sv
// beep_pkg: note codes, FSM states and the half-period table
// shared by the buzzer tone decoder and its classifier.
package beep_pkg;

    typedef enum logic [3:0] {
        NOTE_NONE = 4'd0,
        NOTE_DO   = 4'd1,
        NOTE_RE   = 4'd2,
        NOTE_MI   = 4'd3,
        NOTE_FA   = 4'd4,
        NOTE_SO   = 4'd5,
        NOTE_LA   = 4'd6,
        NOTE_SI   = 4'd7,
        NOTE_DO_  = 4'd8
    } note_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_TRACK = 2'd2
    } dec_state_e;

    localparam int          NUM_NOTES = 8;
    localparam logic [31:0] REF_HZ    = 32'd12000000;

    // Nominal half-periods in clk cycles at REF_HZ, index 0 = DO.
    function automatic logic [15:0] half_ref(input logic [2:0] idx);
        logic [15:0] h;
        case (idx)
            3'd0:    h = 16'd22901;
            3'd1:    h = 16'd20408;
            3'd2:    h = 16'd18182;
            3'd3:    h = 16'd17192;
            3'd4:    h = 16'd15306;
            3'd5:    h = 16'd13636;
            3'd6:    h = 16'd12146;
            default: h = 16'd11472;
        endcase
        return h;
    endfunction

    // Table rescaled to another clock; exact at REF_HZ.
    function automatic logic [15:0] half_at(
        input logic [2:0]  idx,
        input logic [31:0] clk_hz
    );
        return 16'((64'(half_ref(idx)) * 64'(clk_hz)) / 64'(REF_HZ));
    endfunction

endpackage

// File: rtl/beep_note_classify.sv
// beep_note_classify: maps a measured half-period to a note code
// through eight tolerance windows; the lowest matching note wins.
module beep_note_classify
    import beep_pkg::*;
#(
    parameter logic [31:0] CLK_HZ    = 32'd12000000,
    parameter logic [2:0]  TOL_SHIFT = 3'd6
) (
    input  logic [15:0] len,
    output logic [3:0]  cls
);

    logic [15:0] nom;
    logic [15:0] tol;
    logic [15:0] diff;

    // Scan from the top note down so the lowest match is kept last.
    always_comb begin
        cls  = NOTE_NONE;
        nom  = '0;
        tol  = '0;
        diff = '0;
        for (int k = NUM_NOTES - 1; k >= 0; k--) begin
            nom  = half_at(3'(k), CLK_HZ);
            tol  = nom >> TOL_SHIFT;
            diff = (len >= nom) ? (len - nom) : (nom - len);
            if ((len != 16'hFFFF) && (diff <= tol))
                cls = 4'(k + 1);
        end
    end

endmodule

// File: rtl/beep_tone_decoder.sv
// beep_tone_decoder: measures square-wave half-periods and reports a
// stable scale note. Optional BEEP_DEC_GLITCH_EN drops short halves.
module beep_tone_decoder
    import beep_pkg::*;
#(
    parameter logic [31:0] CLK_HZ      = 32'd12000000,
    parameter logic [2:0]  TOL_SHIFT   = 3'd6,
    parameter logic [3:0]  MATCH_CNT   = 4'd4,
    parameter logic [23:0] TIMEOUT_CYC = 24'd1200000,
    parameter logic [15:0] MIN_HALF    = 16'd64
) (
    input  logic       clk,
    input  logic       i_rst_n,
    input  logic       i_tone,
    output logic [3:0] o_note,
    output logic       o_valid,
    output logic       o_active
);

`ifdef BEEP_DEC_GLITCH_EN
    localparam bit GLITCH_EN = 1'b1;
`else
    localparam bit GLITCH_EN = 1'b0;
`endif

    logic        tone_s1;
    logic        tone_s2;
    logic        tone_prev;
    logic        edge_q;
    logic        strobe;
    logic        timeout;
    logic [15:0] half_cnt;
    logic [23:0] sil_cnt;
    logic [3:0]  cls;
    logic [3:0]  cls_q;
    logic        cls_v;
    logic        cls_first;
    dec_state_e  state;
    dec_state_e  state_d;
    logic [3:0]  cand;
    logic [3:0]  cand_d;
    logic [3:0]  streak;
    logic [3:0]  streak_d;
    logic [3:0]  note_d;
    logic        valid_d;

    // Synchronise the tone and register an either-edge strobe.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tone_s1   <= 1'b0;
            tone_s2   <= 1'b0;
            tone_prev <= 1'b0;
            edge_q    <= 1'b0;
        end else begin
            tone_s1   <= i_tone;
            tone_s2   <= tone_s1;
            tone_prev <= tone_s2;
            edge_q    <= tone_s2 ^ tone_prev;
        end
    end

    assign strobe  = edge_q &&
                     !(GLITCH_EN && (half_cnt < MIN_HALF));
    assign timeout = !strobe &&
                     (sil_cnt == TIMEOUT_CYC - 24'd1);

    // Half-period and silence counters, both restarted by a strobe.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            half_cnt <= '0;
            sil_cnt  <= '0;
        end else begin
            if (strobe)
                half_cnt <= 16'd1;
            else if (half_cnt != 16'hFFFF)
                half_cnt <= half_cnt + 16'd1;
            if (strobe)
                sil_cnt <= 24'd1;
            else if (!timeout)
                sil_cnt <= sil_cnt + 24'd1;
        end
    end

    beep_note_classify #(
        .CLK_HZ    (CLK_HZ),
        .TOL_SHIFT (TOL_SHIFT)
    ) u_classify (
        .len (half_cnt),
        .cls (cls)
    );

    // Latch the class of each measured half for the tracker.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cls_q     <= NOTE_NONE;
            cls_v     <= 1'b0;
            cls_first <= 1'b0;
        end else begin
            cls_v     <= strobe && (state != S_IDLE);
            cls_first <= strobe && (state == S_ARM);
            if (strobe)
                cls_q <= cls;
        end
    end

    // FSM and tracker state register.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= S_IDLE;
            cand    <= NOTE_NONE;
            streak  <= '0;
            o_note  <= NOTE_NONE;
            o_valid <= 1'b0;
        end else begin
            state   <= state_d;
            cand    <= cand_d;
            streak  <= streak_d;
            o_note  <= note_d;
            o_valid <= valid_d;
        end
    end

    // Next state, streak tracking and note commit.
    always_comb begin
        state_d  = state;
        cand_d   = cand;
        streak_d = streak;
        note_d   = o_note;
        valid_d  = 1'b0;
        unique case (state)
            S_IDLE:  if (strobe) state_d = S_ARM;
            S_ARM:   if (strobe) state_d = S_TRACK;
            S_TRACK: state_d = S_TRACK;
            default: state_d = S_IDLE;
        endcase
        if (cls_v) begin
            if (cls_first || (cls_q != cand)) begin
                cand_d   = cls_q;
                streak_d = 4'd1;
            end else if (streak < MATCH_CNT) begin
                streak_d = streak + 4'd1;
            end
            if ((streak_d == MATCH_CNT) && (cand_d != o_note)) begin
                note_d  = cand_d;
                valid_d = 1'b1;
            end
        end
        if (timeout) begin
            state_d  = S_IDLE;
            cand_d   = NOTE_NONE;
            streak_d = '0;
            if (o_note != NOTE_NONE) begin
                note_d  = NOTE_NONE;
                valid_d = 1'b1;
            end
        end
    end

    assign o_active = (state == S_TRACK);

endmodule

// File: tb/tb_beep_tone_decoder.sv
// tb_beep_tone_decoder: directed bench for the tone decoder, run at a
// scaled 1.2 MHz clock table with a short silence timeout.
module tb_beep_tone_decoder;

    localparam int H_DO  = 2290;
    localparam int H_LA  = 1363;
    localparam int H_OFF = 2000;
    localparam int TMO   = 6000;

    logic        clk;
    logic        i_rst_n;
    logic        i_tone;
    logic [3:0]  o_note;
    logic        o_valid;
    logic        o_active;
    logic [15:0] c_len;
    logic [3:0]  c_cls;
    logic [3:0]  c_cls_hi;

    int n_chk;
    int n_fail;
    int vcnt;
    int v0;

    beep_tone_decoder #(
        .CLK_HZ      (32'd1200000),
        .TIMEOUT_CYC (24'(TMO))
    ) dut (
        .clk      (clk),
        .i_rst_n  (i_rst_n),
        .i_tone   (i_tone),
        .o_note   (o_note),
        .o_valid  (o_valid),
        .o_active (o_active)
    );

    beep_note_classify u_cls (
        .len (c_len),
        .cls (c_cls)
    );

    beep_note_classify #(
        .CLK_HZ (32'd34340000)
    ) u_cls_hi (
        .len (c_len),
        .cls (c_cls_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (o_valid) vcnt++;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tog(input int n);
        repeat (n) @(posedge clk);
        #1 i_tone = ~i_tone;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        i_rst_n = 1'b0;
        i_tone  = 1'b0;
        c_len   = 16'd0;
        cyc(5);
        check("rst_note", int'(o_note), 0);
        check("rst_valid", int'(o_valid), 0);
        check("rst_active", int'(o_active), 0);
        i_rst_n = 1'b1;
        cyc(5);

        // Classifier windows at the nominal 12 MHz table.
        c_len = 16'd20090; #1 check("cls_re_lo", int'(c_cls), 2);
        c_len = 16'd20089; #1 check("cls_re_lo_out", int'(c_cls), 0);
        c_len = 16'd20726; #1 check("cls_re_hi", int'(c_cls), 2);
        c_len = 16'd20727; #1 check("cls_re_hi_out", int'(c_cls), 0);
        c_len = 16'd22901; #1 check("cls_do", int'(c_cls), 1);
        c_len = 16'd13636; #1 check("cls_la", int'(c_cls), 6);
        // Saturated length stays unclassified even inside a window.
        c_len = 16'd65000; #1 check("cls_hi_do", int'(c_cls_hi), 1);
        c_len = 16'hFFFF;  #1 check("cls_sat", int'(c_cls_hi), 0);

        // 1: lock onto DO
        v0 = vcnt;
        tog(20);
        tog(H_DO); tog(H_DO); tog(H_DO);
        cyc(8);
        check("t1_pre3", int'(o_note), 0);
        check("t1_active", int'(o_active), 1);
        tog(H_DO - 8);
        cyc(4);
        check("t1_pre", int'(o_note), 0);
        cyc(1);
        check("t1_lock", int'(o_note), 1);
        check("t1_vpulse", int'(o_valid), 1);
        check("t1_vcnt", vcnt - v0, 0);
        cyc(1);
        check("t1_vfall", int'(o_valid), 0);
        check("t1_vcnt1", vcnt - v0, 1);

        // 2: switch to LA
        v0 = vcnt;
        tog(H_LA - 6); tog(H_LA); tog(H_LA);
        cyc(8);
        check("t2_hold", int'(o_note), 1);
        tog(H_LA - 8);
        cyc(8);
        check("t2_la", int'(o_note), 6);
        check("t2_vcnt", vcnt - v0, 1);

        // 3: stop toggling
        v0 = vcnt;
        cyc(TMO - 6);
        check("t3_pre", int'(o_note), 6);
        cyc(1);
        check("t3_sil", int'(o_note), 0);
        check("t3_valid", int'(o_valid), 1);
        check("t3_active", int'(o_active), 0);

        // 4: relock on DO, then an off-key tone
        tog(20);
        tog(H_DO); tog(H_DO); tog(H_DO); tog(H_DO);
        cyc(8);
        check("t4_lock", int'(o_note), 1);
        v0 = vcnt;
        tog(H_OFF - 8); tog(H_OFF); tog(H_OFF);
        cyc(8);
        check("t4_hold", int'(o_note), 1);
        tog(H_OFF - 8);
        cyc(8);
        check("t4_off", int'(o_note), 0);
        check("t4_vcnt", vcnt - v0, 1);

        // 6: short pulse inside a DO tone
        tog(H_DO - 8); tog(H_DO); tog(H_DO); tog(H_DO);
        cyc(8);
        check("t6_lock", int'(o_note), 1);
        v0 = vcnt;
        tog(1000 - 8); tog(5); tog(H_DO - 1005);
        tog(H_DO);
        cyc(8);
        check("t6_note", int'(o_note), 1);
        check("t6_vcnt", vcnt - v0, 0);
        check("t6_active", int'(o_active), 1);

        // 5: asynchronous reset while locked
        v0 = vcnt;
        #3 i_rst_n = 1'b0;
        #1;
        check("t5_note", int'(o_note), 0);
        check("t5_valid", int'(o_valid), 0);
        check("t5_active", int'(o_active), 0);
        cyc(3);
        i_rst_n = 1'b1;
        cyc(20);
        check("t5_vcnt", vcnt - v0, 0);
        check("t5_note_post", int'(o_note), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
